err_metric_sweep: RTL
=====================

ERR_METRIC_SWEEP -- requirements
Module: err_metric_sweep

Interface
REQ-001 Parameter: W, 8, operand width of the approximate multiplier under characterisation (legal 2..8).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  begin sweep; sampled only in IDLE or DONE.
REQ-005 Port: pause  in  1  freeze operand advance and sampling while high.
REQ-006 Port: a  out  W  registered operand A to external multiplier.
REQ-007 Port: b  out  W  registered operand B to external multiplier.
REQ-008 Port: Y  in  2W  approximate product from external combinational multiplier, valid same cycle as a/b.
REQ-009 Port: busy  out  1  high in RUN and DRAIN.
REQ-010 Port: done  out  1  high in DONE (level).
REQ-011 Port: err_count  out  2W+1  count of pairs with Y != a*b.
REQ-012 Port: sum_ed  out  4W  sum of error distance |Y - a*b|.
REQ-013 Port: max_ed  out  2W  maximum error distance seen.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE/DONE with start=1 at edge SHALL clear a, b, err_count, sum_ed, max_ed, stage-1 valid, and enter RUN.
REQ-016 start in RUN or DRAIN SHALL be ignored.
REQ-017 Sweep order SHALL be b inner, a outer: at each RUN edge with pause=0, b increments; on b wrap from 2^W-1 to 0, a increments.
REQ-018 At each RUN edge with pause=0, stage 1 SHALL register ed = |Y - a*b| (exact product computed internally, 2W bits) and set v1=1; otherwise v1=0.
REQ-019 At each edge with v1=1, stage 2 SHALL add ed to sum_ed, increment err_count if ed != 0, and load max_ed with ed if ed > max_ed.
REQ-020 The capture of pair a=b=2^W-1 SHALL move RUN to DRAIN; a and b SHALL hold 2^W-1 in DRAIN and DONE.
REQ-021 DRAIN SHALL last one cycle (final accumulation), then enter DONE.
REQ-022 With start sampled at edge E0 and no pause, done SHALL first be high after edge E0+2^(2W)+1; each paused RUN cycle delays done by one.
REQ-023 pause in DRAIN, IDLE or DONE SHALL have no effect.
REQ-024 Accumulators SHALL NOT saturate or wrap for any Y (widths cover worst case 2^(2W)·(2^(2W)-1)).
REQ-025 err_count, sum_ed, max_ed SHALL hold their values in DONE until the next accepted start.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, a=0, b=0, v1=0, busy=0, done=0, err_count=0, sum_ed=0, max_ed=0, regardless of state or start.
REQ-027 Reset mid-RUN or mid-DRAIN SHALL abandon the sweep; no partial results retained.

Verification
REQ-028 W=8, Y=a*b exact model; start -> done after 65537 edges, err_count=0, sum_ed=0, max_ed=0.
REQ-029 W=8, Y=(a*b) with bit0 forced 0; start -> err_count=16384, sum_ed=16384, max_ed=1.
REQ-030 W=8, Y=0; start -> err_count=65025, sum_ed=1065369600, max_ed=65025.
REQ-031 W=8, bit0-forced model, pause held 100 cycles mid-RUN plus start pulses during RUN -> results identical to REQ-029, done delayed exactly 100 cycles.
REQ-032 Reset asserted at RUN cycle 1000, then fresh start -> all outputs 0 after reset; final results match REQ-029.
REQ-033 W=2, Y=a*b+1 (truncated to 4 bits) -> after 17 edges err_count=16, sum_ed=16, max_ed=1.

Source files
------------

// File: rtl/err_metric_sweep.sv
// Exhaustive operand sweep that characterises an external approximate multiplier,
// accumulating error count, summed error distance and worst-case error distance.
module err_metric_sweep #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    input  logic [2*W-1:0]   Y,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [4*W-1:0]   sum_ed,
    output logic [2*W-1:0]   max_ed
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [W-1:0] OP_MAX = {W{1'b1}};

    state_t           state;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   ed_now;
    logic [2*W-1:0]   ed1;
    logic             v1;

    assign exact  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign ed_now = (Y >= exact) ? (Y - exact) : (exact - Y);

    // Stage 2 accumulates the previous capture; a start in IDLE/DONE overrides it with a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            ed1       <= '0;
            v1        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else begin
            if (v1) begin
                sum_ed <= sum_ed + {{(2*W){1'b0}}, ed1};
                if (ed1 != '0)
                    err_count <= err_count + (2*W+1)'(1);
                if (ed1 > max_ed)
                    max_ed <= ed1;
            end

            case (state)
                IDLE, DONE: begin
                    v1 <= 1'b0;
                    if (start) begin
                        a         <= '0;
                        b         <= '0;
                        err_count <= '0;
                        sum_ed    <= '0;
                        max_ed    <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        v1 <= 1'b0;
                    end else begin
                        ed1 <= ed_now;
                        v1  <= 1'b1;
                        // The final pair leaves a and b parked at their maximum.
                        if (a == OP_MAX && b == OP_MAX) begin
                            state <= DRAIN;
                        end else begin
                            b <= b + W'(1);
                            if (b == OP_MAX)
                                a <= a + W'(1);
                        end
                    end
                end
                DRAIN: begin
                    v1    <= 1'b0;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    v1    <= 1'b0;
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
